// File: rtl/jump_redirect_if.sv
// Handshake bundle between the decode-stage jump logic, the fetch redirect port and the controller.
interface jump_redirect_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             jump_valid_d;
    logic [PC_W-1:0]  jump_target_d;
    logic             decode_stall;
    logic             slot_fetched;
    logic             exc_flush;
    logic             redirect_ready;
    logic             jump_accept;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_adel;
    logic             busy;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output jump_valid_d, jump_target_d, decode_stall, slot_fetched, exc_flush, redirect_ready,
        input  jump_accept, redirect_valid, redirect_pc, redirect_adel, busy, redirect_cnt
    );

    modport slave (
        input  jump_valid_d, jump_target_d, decode_stall, slot_fetched, exc_flush, redirect_ready,
        output jump_accept, redirect_valid, redirect_pc, redirect_adel, busy, redirect_cnt
    );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// Delivers a resolved jump target to fetch as a PC redirect, only after the delay slot is fetched.
//   state       | meaning
//   IDLE        | no jump pending; may accept one from decode
//   WAIT_SLOT   | target held, waiting for the delay-slot instruction to be fetched
//   WAIT_ACCEPT | redirect presented to fetch, waiting for redirect_ready
module jump_redirect_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic resetn,
    jump_redirect_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SLOT   = 2'd1,
        WAIT_ACCEPT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               rvalid;
    logic               handshake;

    always_comb begin
        accept    = (state_q == IDLE) & bus.jump_valid_d & ~bus.decode_stall & ~bus.exc_flush;
        rvalid    = (state_q == WAIT_ACCEPT) & ~bus.exc_flush;
        handshake = rvalid & bus.redirect_ready;
    end

    // A flush abandons any pending work but keeps tgt_q; the exception path owns the PC.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (bus.exc_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tgt_d   = bus.jump_target_d;
                        state_d = bus.slot_fetched ? WAIT_ACCEPT : WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (bus.slot_fetched) state_d = WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    if (handshake) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while resetn is held so nothing leaks out during reset.
    always_comb begin
        bus.jump_accept    = resetn & accept;
        bus.redirect_valid = resetn & rvalid;
        bus.redirect_pc    = resetn ? tgt_q : '0;
        bus.redirect_adel  = resetn & rvalid & (tgt_q[1:0] != 2'b00);
        bus.busy           = resetn & (state_q != IDLE);
        bus.redirect_cnt   = resetn ? cnt_q : '0;
    end
endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl; redirects are checked by a scoreboard monitor on handshake.
module tb_jump_redirect_ctrl;
    logic clk;
    logic resetn;

    jump_redirect_if #(.PC_W(32), .CNT_W(32)) bus ();

    jump_redirect_ctrl #(.PC_W(32), .CNT_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every completed redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.redirect_valid === 1'b1 && bus.redirect_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_redirect", 64'(bus.redirect_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_redirect_pc", 64'(bus.redirect_pc), 64'(e.pc));
                chk("sb_redirect_adel", 64'(bus.redirect_adel), 64'(e.adel));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic jv, input logic [31:0] tgt, input logic stall,
                       input logic slot, input logic flush, input logic rdy);
        bus.jump_valid_d   = jv;
        bus.jump_target_d  = tgt;
        bus.decode_stall   = stall;
        bus.slot_fetched   = slot;
        bus.exc_flush      = flush;
        bus.redirect_ready = rdy;
    endtask

    task automatic push(input logic [31:0] pc, input logic adel);
        exp_t e;
        e.pc   = pc;
        e.adel = adel;
        exp_q.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        drv(0, 32'h0, 0, 0, 0, 0);
        tick();
        drv(1, 32'h1234_5678, 0, 1, 0, 1);
        @(negedge clk);
        chk("rst_jump_accept", 64'(bus.jump_accept), 0);
        chk("rst_redirect_valid", 64'(bus.redirect_valid), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        tick();
        resetn = 1'b1;
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 0);
        chk("idle_redirect_valid", 64'(bus.redirect_valid), 0);
        chk("idle_cnt", 64'(bus.redirect_cnt), 0);
        chk("idle_pc", 64'(bus.redirect_pc), 0);

        // Slot already fetched, fetch ready: minimum latency.
        tick();
        drv(1, 32'hBFC0_0100, 0, 1, 0, 1);
        push(32'hBFC0_0100, 1'b0);
        @(negedge clk);
        chk("fast_accept", 64'(bus.jump_accept), 1);
        chk("fast_busy_n", 64'(bus.busy), 0);
        tick();
        drv(0, 32'h0, 0, 0, 0, 1);
        @(negedge clk);
        chk("fast_valid_n1", 64'(bus.redirect_valid), 1);
        chk("fast_pc_n1", 64'(bus.redirect_pc), 64'hBFC0_0100);
        chk("fast_busy_n1", 64'(bus.busy), 1);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fast_busy_n2", 64'(bus.busy), 0);
        chk("fast_cnt_n2", 64'(bus.redirect_cnt), 1);

        // Slot late, fetch back-pressured; a new jump offered while busy must be ignored.
        tick();
        drv(1, 32'h0040_1000, 0, 0, 0, 0);
        @(negedge clk);
        chk("late_accept", 64'(bus.jump_accept), 1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            drv((c <= 5), 32'hDEAD_0000, 0, (c == 3), 0, (c == 6));
            if (c == 6) push(32'h0040_1000, 1'b0);
            @(negedge clk);
            chk($sformatf("late_valid_c%0d", c), 64'(bus.redirect_valid), (c >= 4) ? 1 : 0);
            chk($sformatf("late_busy_c%0d", c), 64'(bus.busy), 1);
            chk($sformatf("late_accept_c%0d", c), 64'(bus.jump_accept), 0);
            chk($sformatf("late_pc_c%0d", c), 64'(bus.redirect_pc), 64'h0040_1000);
        end
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("late_busy_n7", 64'(bus.busy), 0);
        chk("late_cnt_n7", 64'(bus.redirect_cnt), 2);

        // Decode stall gating: target must not be captured while stalled.
        for (int c = 0; c < 3; c++) begin
            tick();
            drv(1, 32'h0000_3000, 1, 1, 0, 0);
            @(negedge clk);
            chk($sformatf("stall_accept_c%0d", c), 64'(bus.jump_accept), 0);
            chk($sformatf("stall_pc_c%0d", c), 64'(bus.redirect_pc), 64'h0040_1000);
        end
        tick();
        drv(1, 32'h0000_2000, 0, 1, 0, 0);
        @(negedge clk);
        chk("stall_release_accept", 64'(bus.jump_accept), 1);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_valid", 64'(bus.redirect_valid), 1);
        chk("stall_pc_latched", 64'(bus.redirect_pc), 64'h0000_2000);

        // Flush together with ready in WAIT_ACCEPT: flush wins, no handshake.
        tick();
        drv(0, 32'h0, 0, 0, 1, 1);
        @(negedge clk);
        chk("flush_valid", 64'(bus.redirect_valid), 0);
        chk("flush_accept", 64'(bus.jump_accept), 0);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 0);
        chk("flush_cnt", 64'(bus.redirect_cnt), 2);
        chk("flush_tgt_kept", 64'(bus.redirect_pc), 64'h0000_2000);

        // Misaligned jr target: adel follows redirect_valid exactly.
        tick();
        drv(1, 32'h8000_0002, 0, 0, 0, 0);
        @(negedge clk);
        chk("adel_accept", 64'(bus.jump_accept), 1);
        chk("adel_idle", 64'(bus.redirect_adel), 0);
        tick();
        drv(0, 32'h0, 0, 1, 0, 0);
        @(negedge clk);
        chk("adel_wait_slot", 64'(bus.redirect_adel), 0);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("adel_valid", 64'(bus.redirect_valid), 1);
        chk("adel_high", 64'(bus.redirect_adel), 1);
        chk("adel_pc", 64'(bus.redirect_pc), 64'h8000_0002);
        tick();
        drv(0, 32'h0, 0, 0, 0, 1);
        push(32'h8000_0002, 1'b1);
        @(negedge clk);
        chk("adel_hs", 64'(bus.redirect_adel), 1);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("adel_after", 64'(bus.redirect_adel), 0);
        chk("adel_cnt", 64'(bus.redirect_cnt), 3);

        // Flush in WAIT_SLOT returns to IDLE.
        tick();
        drv(1, 32'h0000_4000, 0, 0, 0, 0);
        tick();
        drv(0, 32'h0, 0, 0, 1, 0);
        @(negedge clk);
        chk("flush_slot_busy", 64'(bus.busy), 1);
        tick();
        drv(0, 32'h0, 0, 1, 0, 1);
        @(negedge clk);
        chk("flush_slot_idle", 64'(bus.busy), 0);
        chk("flush_slot_valid", 64'(bus.redirect_valid), 0);

        // Reset while a redirect is pending drops it.
        tick();
        drv(1, 32'h0000_0100, 0, 1, 0, 0);
        tick();
        drv(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_pending", 64'(bus.redirect_valid), 1);
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_valid_low", 64'(bus.redirect_valid), 0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 0);
        chk("midrst_cnt", 64'(bus.redirect_cnt), 0);
        chk("midrst_pc", 64'(bus.redirect_pc), 0);

        chk("sb_drained", 64'(exp_q.size()), 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
